patch_sum_collector: RTL
========================

Name: patch_sum_collector

Overview:
Sits directly downstream of the bank of N_REDUCER patch row reducers.
- Captures each reducer's one-cycle done pulse together with its patch number, matcher row and final sum.
- Serialises simultaneous completions through a round-robin arbiter into a FIFO.
- Streams records out on a valid/ready interface to the patch accumulation / host-readout stage.

Parameters:
N_REDUCER, 4, number of upstream row reducers (>=2)
N_PATCH, 64, patch count; patch number width = log2(N_PATCH)
N_ROW_SIZE, 11, row index width
FP_SIZE, 32, width of the floating-point sum (passed through, never interpreted)
FIFO_DEPTH, 16, output FIFO entries (power of 2)

Ports:
clk  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
done  in  N_REDUCER  per-reducer one-cycle completion pulse
num_in  in  N_REDUCER*log2(N_PATCH)  patch number of reducer i at [i*W+:W]
row_in  in  N_REDUCER*N_ROW_SIZE  matcher row of reducer i
sum_in  in  N_REDUCER*FP_SIZE  final sum of reducer i
out_valid  out  1  FIFO head holds a record
out_ready  in  1  consumer accepts head this cycle
out_num  out  log2(N_PATCH)  head patch number
out_row  out  N_ROW_SIZE  head row
out_sum  out  FP_SIZE  head sum
out_src  out  log2(N_REDUCER)  index of the reducer that produced the head record
fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky: a capture was lost
clear_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (reset_n low, async): pend[], rr_ptr, FIFO pointers and count are 0; out_valid=0, out_num/out_row/out_sum/out_src=0, overflow=0. Reset mid-operation discards all pending and queued records.
- Capture, edge ending cycle t with done[i]=1:
  - pend[i]<=1.
  - slot[i] captures num_in, row_in and sum_in slice i.
  - Capture is unconditional; upstream data is valid only in the done cycle.
- Capture collision: done[i] while pend[i]=1 and slot i is not granted in that same cycle:
  - new data overwrites slot i;
  - overflow<=1 (the older record is lost).
- Arbitration, each cycle:
  - Grant only when some pend[j]=1 and fifo_count < FIFO_DEPTH; a simultaneous pop does not free space that cycle.
  - Grant the first pend[j] searching from rr_ptr upward, mod N_REDUCER.
  - On grant j: pend[j]<=0, FIFO writes {slot j, j}, rr_ptr<=(j+1) mod N_REDUCER.
  - At most one grant per cycle.
- Same-cycle grant and new done on slot j: the new capture wins (pend[j] stays 1 with the new data); the granted old data is written; no overflow.
- FIFO is first-word-fall-through.
  - out_* reflect the head whenever out_valid=1; out_* are don't-care when out_valid=0.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged.
- Latency: done in cycle t -> pend visible t+1 -> granted t+1 (if FIFO not full) -> out_valid=1 in cycle t+2 when the FIFO was empty.
- Full: pending slots wait with no loss; loss occurs only via a capture collision.
- Empty: out_valid=0; out_ready is ignored.
- overflow: set as above, cleared by clear_overflow; a set in the same cycle as clear wins.
- Pointers wrap mod FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.

Decomposition:
- Shared package holds:
  - record field widths (PATCH_NUM_W = log2(N_PATCH), N_ROW_SIZE, FP_SIZE);
  - the packed record layout {src, num, row, sum} and its total width;
  - the log2 function already used codebase-wide.
- One sub-module: sync_fifo_fwft (WIDTH, DEPTH; push, pop, din, dout, count, empty, full), reusable elsewhere.
- Capture slots and the round-robin arbiter stay in the top.

Test Plan:
- Single record: done[2] with num=5, row=100, sum=32'h3F800000, FIFO empty, out_ready=1 -> out_valid high exactly 2 cycles later with out_num=5, out_row=100, out_sum=32'h3F800000, out_src=2, for 1 cycle.
- All 4 done at once, rr_ptr=0, out_ready=1 -> records emerge in src order 0,1,2,3 on consecutive cycles; next simultaneous burst starts at src 0 again (rr_ptr wrapped).
- Backpressure: out_ready=0, 20 records injected spaced 4 cycles apart across reducers -> fifo_count saturates at 16, remaining pend held, overflow=0; after raising out_ready, all 20 drain in grant order.
- Collision: FIFO full, done[1] twice 3 cycles apart -> overflow=1; only the second record's data later emerges for src 1; clear_overflow pulse -> overflow=0.
- Same-cycle grant plus new done on slot 0 -> both records delivered in order, overflow stays 0.
- Reset: reset_n low with 5 queued and 2 pending -> out_valid=0 and fifo_count=0 immediately, before the next clk edge; after release, no stale record appears.

Source files
------------

// File: rtl/patch_sum_collector_pkg.sv
// Shared record layout and sizing helpers for the patch sum collection path.
package patch_sum_collector_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    localparam int unsigned N_REDUCER_DEF  = 4;
    localparam int unsigned N_PATCH_DEF    = 64;
    localparam int unsigned FIFO_DEPTH_DEF = 16;

    localparam int unsigned PATCH_NUM_W = clog2(N_PATCH_DEF);
    localparam int unsigned ROW_W       = 11;
    localparam int unsigned SUM_W       = 32;
    localparam int unsigned SRC_W       = clog2(N_REDUCER_DEF);

    typedef struct packed {
        logic [SRC_W-1:0]       src;
        logic [PATCH_NUM_W-1:0] num;
        logic [ROW_W-1:0]       row;
        logic [SUM_W-1:0]       sum;
    } rec_t;

    localparam int unsigned REC_W = $bits(rec_t);

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two.
module sync_fifo_fwft
    import patch_sum_collector_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [clog2(DEPTH):0]   count,
    output logic                    empty,
    output logic                    full
);
    localparam int unsigned AW = clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        empty  = (r_count == '0);
        full   = (r_count == CNT_FULL);
        w_push = push && !full;
        w_pop  = pop && !empty;
        dout   = r_mem[r_rd_ptr];
        count  = r_count;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
        end
    end

endmodule

// File: rtl/patch_sum_collector.sv
// Collects per-reducer completion records, round-robin arbitrates them into
// a FWFT FIFO and streams them out on a valid/ready interface.
module patch_sum_collector
    import patch_sum_collector_pkg::*;
#(
    parameter int unsigned N_REDUCER  = 4,
    parameter int unsigned N_PATCH    = 64,
    parameter int unsigned N_ROW_SIZE = 11,
    parameter int unsigned FP_SIZE    = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [N_REDUCER-1:0]                  done,
    input  logic [N_REDUCER*clog2(N_PATCH)-1:0]   num_in,
    input  logic [N_REDUCER*N_ROW_SIZE-1:0]       row_in,
    input  logic [N_REDUCER*FP_SIZE-1:0]          sum_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [clog2(N_PATCH)-1:0]             out_num,
    output logic [N_ROW_SIZE-1:0]                 out_row,
    output logic [FP_SIZE-1:0]                    out_sum,
    output logic [clog2(N_REDUCER)-1:0]           out_src,
    output logic [clog2(FIFO_DEPTH):0]            fifo_count,
    output logic                                  overflow,
    input  logic                                  clear_overflow
);
    localparam int unsigned PW = clog2(N_PATCH);
    localparam int unsigned SW = clog2(N_REDUCER);
    localparam int unsigned RW = SW + PW + N_ROW_SIZE + FP_SIZE;

    logic [N_REDUCER-1:0]  r_pend;
    logic [PW-1:0]         r_slot_num [N_REDUCER];
    logic [N_ROW_SIZE-1:0] r_slot_row [N_REDUCER];
    logic [FP_SIZE-1:0]    r_slot_sum [N_REDUCER];
    logic [SW-1:0]         r_rr_ptr;
    logic                  r_overflow;

    logic                  w_gnt_valid;
    logic [SW-1:0]         w_gnt_idx;
    logic [N_REDUCER-1:0]  w_gnt_onehot;
    logic                  w_collide;
    logic [RW-1:0]         w_fifo_din;
    logic [RW-1:0]         w_fifo_dout;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;

    // First pending slot at or after rr_ptr; no grant while the FIFO is full.
    always_comb begin
        int unsigned j;
        j            = 0;
        w_gnt_valid  = 1'b0;
        w_gnt_idx    = '0;
        w_gnt_onehot = '0;
        for (int unsigned k = 0; k < N_REDUCER; k++) begin
            j = (32'(r_rr_ptr) + k) % N_REDUCER;
            if (!w_gnt_valid && r_pend[j] && !w_fifo_full) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = SW'(j);
            end
        end
        if (w_gnt_valid) w_gnt_onehot[w_gnt_idx] = 1'b1;
        w_collide  = |(done & r_pend & ~w_gnt_onehot);
        w_fifo_din = {w_gnt_idx, r_slot_num[w_gnt_idx], r_slot_row[w_gnt_idx],
                      r_slot_sum[w_gnt_idx]};
    end

    // A new capture takes priority over clearing the slot that is being granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
            for (int unsigned i = 0; i < N_REDUCER; i++) begin
                r_slot_num[i] <= '0;
                r_slot_row[i] <= '0;
                r_slot_sum[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REDUCER; i++) begin
                if (done[i]) begin
                    r_pend[i]     <= 1'b1;
                    r_slot_num[i] <= num_in[i*PW +: PW];
                    r_slot_row[i] <= row_in[i*N_ROW_SIZE +: N_ROW_SIZE];
                    r_slot_sum[i] <= sum_in[i*FP_SIZE +: FP_SIZE];
                end else if (w_gnt_onehot[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_valid) begin
            r_rr_ptr <= (w_gnt_idx == SW'(N_REDUCER - 1)) ? '0 : w_gnt_idx + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            r_overflow <= 1'b0;
        else if (w_collide)      r_overflow <= 1'b1;
        else if (clear_overflow) r_overflow <= 1'b0;
    end

    sync_fifo_fwft #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_gnt_valid),
        .pop     (out_ready),
        .din     (w_fifo_din),
        .dout    (w_fifo_dout),
        .count   (fifo_count),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full)
    );

    // Head fields forced to zero when empty so reset shows a clean bus.
    always_comb begin
        out_valid = !w_fifo_empty;
        {out_src, out_num, out_row, out_sum} = w_fifo_empty ? '0 : w_fifo_dout;
        overflow  = r_overflow;
    end

endmodule
